// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, optional skid entry and flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall/flush performance counters.
module pipe_stage_hs #(
    parameter int unsigned       DATA_W  = 64,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int unsigned       MODE    = 0
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int unsigned       CNT_W   = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_BUSY,
        ST_FULL
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              rdy_q, rdy_d;
    logic              in_xfer;
    logic              out_xfer;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;
    // MODE 0 breaks the ready chain with a flop; MODE 1 passes it through.
    assign in_ready_o  = (MODE == 0) ? rdy_q : (~out_valid_o | out_ready_i);
    assign in_xfer     = in_valid_i & in_ready_o;
    assign out_xfer    = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d = ST_BUSY;
                    main_d  = in_data_i;
                end
            end
            ST_BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data_i;
                end else if (in_xfer) begin
                    state_d = ST_FULL;
                    skid_d  = in_data_i;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush drops everything, including a same-cycle input, but leaves payload flops untouched.
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        rdy_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && !(&stall_q)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush_i && !(&flush_q)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Randomized bench for pipe_stage_hs: MODE 0 and MODE 1 instances
// checked every cycle against a capacity-bounded FIFO reference model.
module tb_pipe_stage_hs;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data [2];
    logic [DW-1:0] out_data [2];
`ifdef PIPE_STAGE_PERF_EN
    logic [3:0]    scnt [2];
    logic [3:0]    fcnt [2];
`endif

    pipe_stage_hs #(.DATA_W(DW), .MODE(0)
`ifdef PIPE_STAGE_PERF_EN
        , .CNT_W(4)
`endif
    ) u_m0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush[0]),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0])
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(scnt[0]), .flush_cnt_o(fcnt[0])
`endif
    );

    pipe_stage_hs #(.DATA_W(DW), .MODE(1)
`ifdef PIPE_STAGE_PERF_EN
        , .CNT_W(4)
`endif
    ) u_m1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush[1]),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1])
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(scnt[1]), .flush_cnt_o(fcnt[1])
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: an in-order queue of at most 2 (MODE 0) or 1 (MODE 1) items.
    logic [DW-1:0] fifo [2][2];
    int            cnt  [2];
    logic [DW-1:0] last [2];
    logic [1:0]    pend;
    int            m_stall [2];
    int            m_flush [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            cnt[m]     = 0;
            last[m]    = '0;
            m_stall[m] = 0;
            m_flush[m] = 0;
        end
        pend = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        flush     = 2'b00;
        in_valid  = 2'b11;
        in_data[0] = 16'd5;
        in_data[1] = 16'd5;
        out_ready = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 2'b00;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst_valid%0d", m), 64'(out_valid[m]), 64'd0);
            chk($sformatf("rst_data%0d", m), 64'(out_data[m]), 64'd0);
            chk($sformatf("rst_ready%0d", m), 64'(in_ready[m]), 64'd1);
`ifdef PIPE_STAGE_PERF_EN
            chk($sformatf("rst_scnt%0d", m), 64'(scnt[m]), 64'd0);
            chk($sformatf("rst_fcnt%0d", m), 64'(fcnt[m]), 64'd0);
`endif
        end
    endtask

    task automatic step(input int pr);
        logic exp_v, exp_r, acc_in, acc_out;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            flush[m]     = ($urandom_range(0, 11) == 0);
            out_ready[m] = ($urandom_range(0, 99) < pr);
            if (!pend[m]) begin
                in_valid[m] = ($urandom_range(0, 3) != 0);
                in_data[m]  = DW'($urandom);
            end
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            exp_v = (cnt[m] > 0);
            exp_r = (m == 0) ? (cnt[m] < 2) : (cnt[m] == 0 || out_ready[m]);
            chk($sformatf("valid%0d", m), 64'(out_valid[m]), 64'(exp_v));
            chk($sformatf("ready%0d", m), 64'(in_ready[m]), 64'(exp_r));
            chk($sformatf("data%0d", m), 64'(out_data[m]),
                64'(exp_v ? fifo[m][0] : last[m]));
`ifdef PIPE_STAGE_PERF_EN
            chk($sformatf("scnt%0d", m), 64'(scnt[m]), 64'(m_stall[m]));
            chk($sformatf("fcnt%0d", m), 64'(fcnt[m]), 64'(m_flush[m]));
`endif
            acc_in  = in_valid[m] & exp_r;
            acc_out = exp_v & out_ready[m];
            if (exp_v && !out_ready[m] && m_stall[m] < 15) m_stall[m]++;
            if (flush[m] && m_flush[m] < 15) m_flush[m]++;
            if (exp_v) last[m] = fifo[m][0];
            if (flush[m]) begin
                cnt[m] = 0;
            end else begin
                if (acc_out) begin
                    fifo[m][0] = fifo[m][1];
                    cnt[m]--;
                end
                if (acc_in) begin
                    fifo[m][cnt[m]] = in_data[m];
                    cnt[m]++;
                end
            end
            pend[m] = in_valid[m] & ~exp_r;
        end
    endtask

    initial begin
        flush      = '0;
        in_valid   = '0;
        out_ready  = '0;
        in_data[0] = '0;
        in_data[1] = '0;
        model_reset();
        do_reset();
        repeat (300) step(75);
        repeat (300) step(25);
        do_reset();
        repeat (200) step(50);
        repeat (100) step(95);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
